// File: rtl/ram_write_router.sv
// Demuxes the DMA burst buffer's word stream onto six RAM write ports and pages each burst.
// Optional even-parity output wr_par is enabled by defining WR_PARITY_EN.
module ram_write_router #(
   parameter int DD_WIDTH       = 16,
   parameter int RAM_ADDR_WIDTH = 4,
   parameter int PAGE_WIDTH     = 4
) (
   input  logic                               clk_h,
   input  logic                               rst_n,
   input  logic                               in_valid,
   input  logic [2:0]                         in_sel,
   input  logic [RAM_ADDR_WIDTH-1:0]          in_addr,
   input  logic [DD_WIDTH-1:0]                in_data,
   input  logic                               page_clr,
   output logic [5:0]                         wr_en,
   output logic [PAGE_WIDTH+RAM_ADDR_WIDTH-1:0] wr_addr,
   output logic [DD_WIDTH-1:0]                wr_data,
`ifdef WR_PARITY_EN
   output logic                               wr_par,
`endif
   output logic                               burst_done,
   output logic [2:0]                         burst_sel,
   output logic                               busy,
   output logic                               err_sel,
   output logic                               ovf
);

   localparam int BURST_LEN = 2 ** RAM_ADDR_WIDTH;
   localparam int CW        = RAM_ADDR_WIDTH + 1;
   localparam int AW        = PAGE_WIDTH + RAM_ADDR_WIDTH;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                state_q, state_d;
   logic [2:0]            sel_q, sel_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PAGE_WIDTH-1:0] page_q [6];
   logic [PAGE_WIDTH-1:0] page_d [6];

   logic [5:0]            wr_en_q;
   logic [AW-1:0]         wr_addr_q;
   logic [DD_WIDTH-1:0]   wr_data_q;
   logic                  burst_done_q;
   logic [2:0]            burst_sel_q;
   logic                  busy_q;
   logic                  err_sel_q;
   logic                  ovf_q;

   logic                  selValid;
   logic [2:0]            tgtIdx;
   logic [2:0]            doneIdx;
   logic [PAGE_WIDTH-1:0] tgtPage;
   logic                  issue;
   logic                  done;
   logic                  errSet;
   logic                  ovfSet;

   // Target decode: a write always goes to in_sel, which equals sel_q inside a burst.
   always_comb begin
      selValid = (in_sel != 3'd0) && (in_sel != 3'd7);
      tgtIdx   = in_sel - 3'd1;
      doneIdx  = sel_q - 3'd1;
      tgtPage  = '0;
      for (int i = 0; i < 6; i++) begin
         if (tgtIdx == 3'(i)) tgtPage = page_q[i];
      end
   end

   // Burst FSM: counts accepted words, drops invalid or foreign-selector words.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      issue   = 1'b0;
      done    = 1'b0;
      errSet  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (selValid) begin
                  issue   = 1'b1;
                  sel_d   = in_sel;
                  cnt_d   = CW'(1);
                  state_d = S_BURST;
               end else begin
                  errSet = 1'b1;
               end
            end
         end
         S_BURST: begin
            if (in_valid) begin
               if (in_sel == sel_q) begin
                  issue = 1'b1;
                  if (cnt_q == CW'(BURST_LEN - 1)) begin
                     done    = 1'b1;
                     cnt_d   = '0;
                     state_d = S_IDLE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  errSet = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Page counters: a clear beats a coinciding completion and suppresses its overflow.
   always_comb begin
      ovfSet = 1'b0;
      for (int i = 0; i < 6; i++) page_d[i] = page_q[i];
      if (page_clr) begin
         for (int i = 0; i < 6; i++) page_d[i] = '0;
      end else if (done) begin
         for (int i = 0; i < 6; i++) begin
            if (doneIdx == 3'(i)) begin
               page_d[i] = page_q[i] + PAGE_WIDTH'(1);
               if (&page_q[i]) ovfSet = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_h) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < 6; i++) page_q[i] <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < 6; i++) page_q[i] <= page_d[i];
      end
   end

   // Output registers; address and data hold their last values between writes.
   always_ff @(posedge clk_h) begin
      if (!rst_n) begin
         wr_en_q      <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         burst_done_q <= 1'b0;
         burst_sel_q  <= '0;
         busy_q       <= 1'b0;
         err_sel_q    <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         wr_en_q <= issue ? (6'(1) << tgtIdx) : 6'd0;
         if (issue) begin
            wr_addr_q <= {tgtPage, in_addr};
            wr_data_q <= in_data;
         end
         burst_done_q <= done;
         if (done) burst_sel_q <= sel_q;
         busy_q    <= (state_d == S_BURST);
         err_sel_q <= err_sel_q | errSet;
         ovf_q     <= ovf_q | ovfSet;
      end
   end

`ifdef WR_PARITY_EN
   logic wr_par_q;

   always_ff @(posedge clk_h) begin
      if (!rst_n) begin
         wr_par_q <= 1'b0;
      end else if (issue) begin
         wr_par_q <= ^in_data;
      end
   end

   assign wr_par = wr_par_q;
`endif

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign burst_done = burst_done_q;
   assign burst_sel  = burst_sel_q;
   assign busy       = busy_q;
   assign err_sel    = err_sel_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_ram_write_router.sv
// Directed self-checking bench for ram_write_router with hand-computed expectations.
module tb_ram_write_router;

   logic        clk_h = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [2:0]  in_sel;
   logic [3:0]  in_addr;
   logic [15:0] in_data;
   logic        page_clr;
   logic [5:0]  wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        burst_done;
   logic [2:0]  burst_sel;
   logic        busy;
   logic        err_sel;
   logic        ovf;
`ifdef WR_PARITY_EN
   logic        wr_par;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   ram_write_router dut (
      .clk_h(clk_h), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel),
      .in_addr(in_addr), .in_data(in_data), .page_clr(page_clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef WR_PARITY_EN
      .wr_par(wr_par),
`endif
      .burst_done(burst_done), .burst_sel(burst_sel), .busy(busy),
      .err_sel(err_sel), .ovf(ovf)
   );

   always #5 clk_h = ~clk_h;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         $error("[TB] check %s", tag);
      end
   endtask

   // Drive one word for a single clock edge; outputs are sampled 1 time unit after that edge.
   task automatic applyStimulus(input logic valid, input logic [2:0] sel, input logic [3:0] addr, input logic [15:0] data);
      in_valid = valid;
      in_sel   = sel;
      in_addr  = addr;
      in_data  = data;
      @(posedge clk_h);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic logic [5:0] expEn(input logic [2:0] sel);
      case (sel)
         3'd1: return 6'b000001;
         3'd2: return 6'b000010;
         3'd3: return 6'b000100;
         3'd4: return 6'b001000;
         3'd5: return 6'b010000;
         3'd6: return 6'b100000;
         default: return 6'b000000;
      endcase
   endfunction

   task automatic doReset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      page_clr = 1'b0;
      @(posedge clk_h);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".wr_en"}, 32'(wr_en), 32'd0);
      checkOutput({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
      checkOutput({tag, ".wr_data"}, 32'(wr_data), 32'd0);
      checkOutput({tag, ".burst_done"}, 32'(burst_done), 32'd0);
      checkOutput({tag, ".burst_sel"}, 32'(burst_sel), 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".err_sel"}, 32'(err_sel), 32'd0);
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'd0);
`ifdef WR_PARITY_EN
      checkOutput({tag, ".wr_par"}, 32'(wr_par), 32'd0);
`endif
   endtask

   task automatic checkWrite(input string tag, input logic [2:0] sel, input logic [3:0] page,
                             input logic [3:0] addr, input logic [15:0] data, input logic last);
      checkOutput({tag, ".wr_en"}, 32'(wr_en), 32'(expEn(sel)));
      checkOutput({tag, ".wr_addr"}, 32'(wr_addr), 32'({page, addr}));
      checkOutput({tag, ".wr_data"}, 32'(wr_data), 32'(data));
      checkOutput({tag, ".burst_done"}, 32'(burst_done), 32'(last));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(!last));
`ifdef WR_PARITY_EN
      checkOutput({tag, ".wr_par"}, 32'(wr_par), 32'(^data));
`endif
   endtask

   // Full 16-word burst; optional idle cycle after each word and page_clr on the final word.
   task automatic runBurst(input string tag, input logic [2:0] sel, input logic [15:0] base,
                           input logic [3:0] page, input logic gaps, input logic clrLast, input logic expOvf);
      for (int i = 0; i < 16; i++) begin
         page_clr = clrLast && (i == 15);
         applyStimulus(1'b1, sel, 4'(i), base + 16'(i));
         page_clr = 1'b0;
         checkWrite(tag, sel, page, 4'(i), base + 16'(i), i == 15);
         if (i == 15) begin
            checkOutput({tag, ".burst_sel"}, 32'(burst_sel), 32'(sel));
            checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
         end else if (gaps) begin
            applyStimulus(1'b0, sel, 4'(i), 16'hFFFF);
            checkOutput({tag, ".gap.wr_en"}, 32'(wr_en), 32'd0);
            checkOutput({tag, ".gap.busy"}, 32'(busy), 32'd1);
            checkOutput({tag, ".gap.wr_data"}, 32'(wr_data), 32'(base + 16'(i)));
         end
      end
   endtask

   initial begin
      in_sel  = 3'd0;
      in_addr = 4'd0;
      in_data = 16'd0;
      doReset();
      checkAllZero("reset");

      runBurst("input", 3'd1, 16'h0100, 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, 4'd0, 16'd0);
      checkOutput("idle.wr_en", 32'(wr_en), 32'd0);
      checkOutput("idle.burst_done", 32'(burst_done), 32'd0);
      checkOutput("idle.wr_addr_hold", 32'(wr_addr), 32'h0F);
      checkOutput("idle.burst_sel_hold", 32'(burst_sel), 32'd1);

      runBurst("vram0", 3'd4, 16'h4000, 4'd0, 1'b0, 1'b0, 1'b0);
      runBurst("vram1", 3'd4, 16'h4100, 4'd1, 1'b0, 1'b0, 1'b0);
      runBurst("bias0", 3'd6, 16'h6000, 4'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("bias0.err_sel", 32'(err_sel), 32'd0);

      applyStimulus(1'b1, 3'd7, 4'd3, 16'hDEAD);
      checkOutput("badsel.wr_en", 32'(wr_en), 32'd0);
      checkOutput("badsel.err_sel", 32'(err_sel), 32'd1);
      checkOutput("badsel.busy", 32'(busy), 32'd0);
      checkOutput("badsel.wr_data_hold", 32'(wr_data), 32'h600F);

      // Even-point burst with a stray odd-point word injected after the fifth word.
      for (int i = 0; i < 16; i++) begin
         if (i == 5) begin
            applyStimulus(1'b1, 3'd3, 4'd9, 16'hBEEF);
            checkOutput("stray.wr_en", 32'(wr_en), 32'd0);
            checkOutput("stray.busy", 32'(busy), 32'd1);
            checkOutput("stray.err_sel", 32'(err_sel), 32'd1);
         end
         applyStimulus(1'b1, 3'd2, 4'(i), 16'h2000 + 16'(i));
         checkWrite("peven", 3'd2, 4'd0, 4'(i), 16'h2000 + 16'(i), i == 15);
      end
      checkOutput("peven.burst_sel", 32'(burst_sel), 32'd2);

      doReset();
      checkAllZero("reset2");
      for (int b = 0; b < 16; b++) begin
         runBurst("wrap", 3'd5, 16'h5000 + 16'(b * 16), 4'(b), 1'b0, 1'b0, b == 15);
      end
      runBurst("wrap.after", 3'd5, 16'h5A00, 4'd0, 1'b0, 1'b0, 1'b1);

      doReset();
      checkAllZero("reset3");
      runBurst("clr.input", 3'd1, 16'h1100, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int b = 0; b < 16; b++) begin
         runBurst("clr", 3'd5, 16'h5000 + 16'(b * 16), 4'(b), 1'b0, b == 15, 1'b0);
      end
      runBurst("clr.input2", 3'd1, 16'h1200, 4'd0, 1'b0, 1'b0, 1'b0);
      runBurst("clr.zram", 3'd5, 16'h5B00, 4'd0, 1'b0, 1'b0, 1'b0);

      doReset();
      runBurst("gaps", 3'd1, 16'h0A00, 4'd0, 1'b1, 1'b0, 1'b0);

      runBurst("mid.pre", 3'd4, 16'h4400, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'd4, 4'(i), 16'h4500 + 16'(i));
         checkWrite("mid.partial", 3'd4, 4'd1, 4'(i), 16'h4500 + 16'(i), 1'b0);
      end
      doReset();
      checkAllZero("midreset");
      runBurst("mid.post", 3'd4, 16'h4600, 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef WR_PARITY_EN
      applyStimulus(1'b1, 3'd1, 4'd0, 16'h0007);
      checkOutput("par.odd", 32'(wr_par), 32'd1);
      applyStimulus(1'b1, 3'd1, 4'd1, 16'h0003);
      checkOutput("par.even", 32'(wr_par), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ram_write_router.md
Name: ram_write_router

Overview:
- Downstream of the DMA burst buffer.
- Consumes the buffer's serial word stream: 16-bit data, 4-bit local address, 3-bit RAM selector and a write-valid strobe.
- Demuxes each word onto one of six on-chip RAM write ports: input, point_even, point_odd, v_ram, z_ram, bias_ram.
- Extends the 4-bit local address with a per-target page counter, so successive 16-word bursts land in consecutive RAM pages.

Parameters:
- DD_WIDTH, 16, data word width.
- RAM_ADDR_WIDTH, 4, local (in-burst) address width; burst length = 2**RAM_ADDR_WIDTH.
- PAGE_WIDTH, 4, per-target page counter width; wr_addr width = PAGE_WIDTH+RAM_ADDR_WIDTH.

Ports:
- clk_h  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  word-valid strobe from buffer (to_ram_ready).
- in_sel  in  3  target selector: 001 input, 010 point_even, 011 point_odd, 100 v_ram, 101 z_ram, 110 bias_ram; 000/111 invalid.
- in_addr  in  RAM_ADDR_WIDTH  local word address.
- in_data  in  DD_WIDTH  word data.
- page_clr  in  1  synchronous clear of all six page counters.
- wr_en  out  6  one-hot write enable; bit i serves selector i+1.
- wr_addr  out  PAGE_WIDTH+RAM_ADDR_WIDTH  {page[target], in_addr}.
- wr_data  out  DD_WIDTH  registered in_data.
- burst_done  out  1  one-cycle pulse when a target receives its last burst word.
- burst_sel  out  3  selector of the burst just completed; valid with burst_done.
- busy  out  1  high while in S_BURST.
- err_sel  out  1  sticky: invalid selector, or selector change mid-burst.
- ovf  out  1  sticky: a page counter wrapped.

Behaviour:
- Reset (rst_n=0 at clk_h edge):
  - wr_en=0, wr_addr=0, wr_data=0, burst_done=0, burst_sel=0, busy=0, err_sel=0, ovf=0.
  - All page counters = 0; state = S_IDLE; word counter = 0.
  - Reset mid-burst discards the partial burst; pages do not advance.
- All outputs are registered. Write latency = 1 cycle from in_valid sample to wr_en.
- States: S_IDLE, S_BURST.
- S_IDLE:
  - in_valid=1 with valid in_sel: latch in_sel into sel_q, word counter = 1, issue write, go to S_BURST.
  - in_valid=1 with invalid in_sel: drop the word, set err_sel, stay in S_IDLE.
- S_BURST:
  - in_valid=1 and in_sel==sel_q: issue write, increment word counter.
  - When the counter reaches 2**RAM_ADDR_WIDTH on a write:
    - pulse burst_done and set burst_sel=sel_q in the same cycle the last wr_en is asserted;
    - increment page[sel_q] modulo 2**PAGE_WIDTH;
    - return to S_IDLE.
  - in_valid=1 and in_sel!=sel_q: drop the word, set err_sel, stay in S_BURST. The counter does not advance.
  - in_valid=0: hold state (gaps allowed).
- Write issue: wr_en[sel-1]=1, wr_addr={page[sel], in_addr}, wr_data=in_data, all on the next cycle. in_addr is passed through unmodified; the router does not check its ordering.
- Page wrap: if page[sel_q] is all-ones when a burst completes, it wraps to 0 and ovf is set.
- page_clr:
  - Clears all pages on the next edge.
  - Coinciding with a burst completion: the clear wins, page = 0, and ovf is not set by that completion.
  - Does not affect the state machine or the word counter.
- err_sel and ovf clear only on reset.
- When no write is issued, wr_en=0; wr_addr and wr_data hold their last values.

Optional Feature:
- Macro WR_PARITY_EN.
- Defined: adds output port wr_par (1 bit), registered alongside wr_data, equal to the XOR-reduce (even parity) of in_data for the issued word. Its reset value is 0.
- Undefined: the port is absent and the logic is identical otherwise.

Test Plan:
- Reset, then a 16-word burst with sel=001, data 0x0100..0x010F, addr 0..15:
  - wr_en=6'b000001 for 16 cycles, wr_addr 0x00..0x0F;
  - burst_done pulses with the 16th write, burst_sel=001, busy falls.
- Two consecutive sel=100 bursts, then one sel=110 burst:
  - second v_ram burst uses wr_addr 0x10..0x1F;
  - bias burst uses 0x00..0x0F on wr_en bit 5.
- Invalid selector and mid-burst change:
  - in_valid with sel=111 in S_IDLE -> no wr_en, err_sel=1;
  - a word with sel=011 inside a sel=010 burst -> dropped, counter unchanged, burst still completes after 16 valid words.
- Page wrap and clear race:
  - 16 bursts on sel=101 -> page wraps to 0, ovf=1 at the 16th burst_done;
  - repeat after reset with page_clr asserted on the 16th completion cycle -> ovf stays 0.
- Gaps and reset mid-burst:
  - in_valid toggled 1/0 over a burst -> exactly 16 writes, busy held high throughout;
  - rst_n=0 after 8 words -> all outputs 0, and the next burst starts at page 0.
- WR_PARITY_EN defined: data 0x0007 -> wr_par=1; data 0x0003 -> wr_par=0.
